// File: rtl/cache_types.sv
// Shared cache-side types and constants.
// Used by the cache line / memory burst adapter.
package cache_types;

    localparam int BURST_WIDTH = 64;
    localparam int BEATS       = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_COLLECT,
        WR_BURST,
        RESP
    } adapter_state_t;

endpackage

// File: rtl/cacheline_adapter.sv
// Cache line to memory burst adapter.
// Splits line writes into beats and assembles read beats into a line.
module cacheline_adapter #(
    parameter int CACHE_LINE_SIZE = 256,
    parameter int BURST_WIDTH     = cache_types::BURST_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                mem_addr,
    input  logic                       mem_read,
    input  logic                       mem_write,
    input  logic [CACHE_LINE_SIZE-1:0] mem_wdata,
    output logic                       mem_resp,
    output logic [CACHE_LINE_SIZE-1:0] mem_line,
    output logic [31:0]                bmem_addr,
    output logic                       bmem_read,
    output logic                       bmem_write,
    output logic [BURST_WIDTH-1:0]     bmem_wdata,
    input  logic                       bmem_ready,
    input  logic [BURST_WIDTH-1:0]     bmem_rdata,
    input  logic                       bmem_rvalid
);

    import cache_types::adapter_state_t;
    import cache_types::IDLE;
    import cache_types::RD_REQ;
    import cache_types::RD_COLLECT;
    import cache_types::WR_BURST;
    import cache_types::RESP;

    localparam logic [1:0]  LAST_BEAT = 2'(cache_types::BEATS - 1);
    localparam logic [31:0] LINE_MASK = ~32'(CACHE_LINE_SIZE / 8 - 1);

    adapter_state_t             state;
    logic [1:0]                 beat_cnt;
    logic [1:0]                 beat_nxt;
    logic [CACHE_LINE_SIZE-1:0] line_q;
    logic [CACHE_LINE_SIZE-1:0] line_next;

    assign beat_nxt = beat_cnt + 2'd1;

    // Line buffer with the incoming read beat merged into its slot.
    always_comb begin
        line_next = line_q;
        line_next[int'(beat_cnt)*BURST_WIDTH +: BURST_WIDTH] = bmem_rdata;
    end

    // Control FSM; every output is registered and cleared outside its phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            line_q     <= '0;
            mem_resp   <= 1'b0;
            mem_line   <= '0;
            bmem_addr  <= '0;
            bmem_read  <= 1'b0;
            bmem_write <= 1'b0;
            bmem_wdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mem_write) begin
                        line_q     <= mem_wdata;
                        beat_cnt   <= '0;
                        bmem_addr  <= mem_addr & LINE_MASK;
                        bmem_write <= 1'b1;
                        bmem_wdata <= mem_wdata[BURST_WIDTH-1:0];
                        state      <= WR_BURST;
                    end else if (mem_read) begin
                        beat_cnt  <= '0;
                        bmem_addr <= mem_addr & LINE_MASK;
                        bmem_read <= 1'b1;
                        state     <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (bmem_ready) begin
                        bmem_read <= 1'b0;
                        bmem_addr <= '0;
                        state     <= RD_COLLECT;
                    end
                end
                RD_COLLECT: begin
                    if (bmem_rvalid) begin
                        line_q   <= line_next;
                        beat_cnt <= beat_nxt;
                        if (beat_cnt == LAST_BEAT) begin
                            mem_resp <= 1'b1;
                            mem_line <= line_next;
                            state    <= RESP;
                        end
                    end
                end
                WR_BURST: begin
                    if (bmem_ready) begin
                        beat_cnt <= beat_nxt;
                        if (beat_cnt == LAST_BEAT) begin
                            bmem_write <= 1'b0;
                            bmem_wdata <= '0;
                            bmem_addr  <= '0;
                            mem_resp   <= 1'b1;
                            mem_line   <= '0;
                            state      <= RESP;
                        end else begin
                            bmem_wdata <=
                                line_q[int'(beat_nxt)*BURST_WIDTH +: BURST_WIDTH];
                        end
                    end
                end
                RESP: begin
                    mem_resp <= 1'b0;
                    mem_line <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
